fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the fixed 16x16 FIFO wrapper used in our test DUTs.
- Adds generic width/depth, programmable full/empty thresholds, occupancy count, valid strobe, registered overflow/underflow and a reset-busy sequence.
- Optional first-word-fall-through mode.
- Sits between a producer and a consumer in the same clock domain. Built from inferred RAM, no vendor IP.

Parameters:
- DATA_WIDTH, 16: width of din/dout in bits (>=1).
- DEPTH, 16: capacity in words; power of 2, >=4.
- PROG_FULL_THRESH, DEPTH-2: prog_full asserts when count >= this value (legal range 1..DEPTH).
- PROG_EMPTY_THRESH, 2: prog_empty asserts when count <= this value (legal range 0..DEPTH-1).
- RST_BUSY_CYCLES, 4: clock cycles wr_rst_busy/rd_rst_busy stay high after resetn deasserts (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- valid  out  1  dout holds a word popped by an accepted read.
- full  out  1  count == DEPTH, or wr_rst_busy.
- almost_full  out  1  count >= DEPTH-1.
- prog_full  out  1  count >= PROG_FULL_THRESH.
- empty  out  1  count == 0, or rd_rst_busy.
- prog_empty  out  1  count <= PROG_EMPTY_THRESH.
- overflow  out  1  one-cycle pulse: previous-cycle write rejected.
- underflow  out  1  one-cycle pulse: previous-cycle read rejected.
- data_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- wr_rst_busy  out  1  write side initialising.
- rd_rst_busy  out  1  read side initialising.

Behaviour:
- Clock/reset: one clock, clk; reset is resetn, asynchronous assert, active-low.
- Reset values, async while resetn=0:
  - Pointers, count, dout = 0; valid, overflow, underflow = 0.
  - full=1, empty=1, wr_rst_busy=1, rd_rst_busy=1.
  - almost_full=0, prog_full=0, prog_empty=1.
- Busy sequence:
  - After resetn rises, a counter runs RST_BUSY_CYCLES edges, then both busy flags drop on the same edge.
  - full drops to 0 with busy; empty stays 1.
  - FSM states: RESET -> BUSY -> RUN. resetn low from any state returns to RESET; contents are lost and busy restarts.
- Write accept: wr_en & ~full at the edge. Stores din at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Read accept: rd_en & ~empty at the edge. rd_ptr increments and wraps modulo DEPTH.
- Count update: +1 on write only, -1 on read only, unchanged when both are accepted.
- Flags: all registered and updated on the same edge as data_count. Full and empty are sampled before the edge.
- Simultaneous wr_en & rd_en:
  - At full: read accepted, write rejected, overflow=1 next cycle; count becomes DEPTH-1.
  - At empty: write accepted, read rejected, underflow=1 next cycle; count becomes 1.
- Overflow: wr_en while full (including during busy) -> overflow high for exactly the next cycle; contents unchanged.
- Underflow: rd_en while empty -> underflow high for exactly the next cycle; dout holds its value, valid=0.
- Standard mode (macro absent):
  - Read latency 1: dout = mem[rd_ptr] and valid=1 on the edge after acceptance.
  - valid=0 in any cycle after a non-accepted read; dout holds its last value.
  - Write-to-empty-deassert latency: 1 cycle.
- Wrap-around: pointers are $clog2(DEPTH) bits with natural wrap. Full/empty derive from data_count, never from pointer equality.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - Head word is presented on dout with valid=1 whenever empty=0; rd_en acknowledges/pops it.
  - Next word (or valid=0 and empty=1) appears on the following edge.
  - Write into empty FIFO -> dout/valid/~empty visible 2 edges after write acceptance (RAM read plus output stage).
  - data_count includes the word in the output stage.
  - Capacity stays DEPTH.
- Undefined: standard mode as described above; no output prefetch stage is built.

Test Plan:
- Reset/busy, RST_BUSY_CYCLES=4: release resetn -> busy high exactly 4 edges, full 1->0 with busy, empty=1, data_count=0. A wr_en during busy -> overflow pulse, count stays 0.
- Fill/drain, DEPTH=16: write 0x0000..0x000F -> full=1 after 16th write, almost_full at count 15, prog_full at count 14. 17th write -> overflow single pulse. Read 16 -> dout sequence 0x0000..0x000F with valid; 17th read -> underflow pulse.
- Wrap: loop 40 writes/reads, 3 words in flight -> data order preserved across pointer wrap, data_count oscillates 0..3, never full.
- Simultaneous at boundaries: at count 16, wr_en&rd_en with din=0xBEEF -> count 15, overflow=1, 0xBEEF not stored. At count 0 -> count 1, underflow=1.
- Async reset mid-stream at count 9 -> all outputs to reset values within the reset cycle, without a clock edge. After busy, data_count=0; next written word 0x1234 is the first read.
- FWFT (FIFO_FWFT_EN defined): write 0xA5A5 into empty -> valid=1, dout=0xA5A5 two edges later with no rd_en. rd_en -> empty=1, valid=0 next edge.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy count and reset-busy sequence.
// Latency: read data one edge after an accepted read; with FIFO_FWFT_EN, head word visible two edges after a write into empty.
// Backpressure: writes while full and reads while empty are dropped and flagged by one-cycle overflow/underflow pulses.
// Optional feature macro: FIFO_FWFT_EN (first-word-fall-through output stage).
module fifo_sync_param #(
  parameter int DATA_WIDTH        = 16,
  parameter int DEPTH             = 16,
  parameter int PROG_FULL_THRESH  = DEPTH - 2,
  parameter int PROG_EMPTY_THRESH = 2,
  parameter int RST_BUSY_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    valid,
  output logic                    full,
  output logic                    almost_full,
  output logic                    prog_full,
  output logic                    empty,
  output logic                    prog_empty,
  output logic                    overflow,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  data_count,
  output logic                    wr_rst_busy,
  output logic                    rd_rst_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(RST_BUSY_CYCLES + 1);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [1:0]            state;
  logic [BW-1:0]         busy_cnt;

  logic                  busy_done;
  logic                  busy_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  dout_load;
  logic                  valid_nxt;
  logic                  empty_nxt;
  logic [CW-1:0]         count_nxt;

  // Flags are registered, so acceptance uses the pre-edge full/empty.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign busy_done = (state != ST_RUN) && (busy_cnt == BW'(RST_BUSY_CYCLES - 1));
  assign busy_nxt  = (state != ST_RUN) && !busy_done;

  // Occupancy: simultaneous accepted write and read cancel out.
  always_comb begin
    count_nxt = data_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = data_count + CW'(1);
      2'b01:   count_nxt = data_count - CW'(1);
      default: count_nxt = data_count;
    endcase
  end

`ifdef FIFO_FWFT_EN
  logic [CW-1:0] ram_words;

  // Output stage holds the head word; refill it from RAM when it is free or being popped.
  always_comb begin
    ram_words = data_count - CW'(valid);
    dout_load = (ram_words != '0) && (!valid || rd_acc);
    valid_nxt = dout_load || (valid && !rd_acc);
    empty_nxt = busy_nxt || !valid_nxt;
  end
`else
  // Standard mode: RAM read happens on the accepting edge, no prefetch.
  always_comb begin
    dout_load = rd_acc;
    valid_nxt = rd_acc;
    empty_nxt = busy_nxt || (count_nxt == '0);
  end
`endif

  // Reset-busy sequencer: RESET -> BUSY -> RUN, busy drops on the RST_BUSY_CYCLES-th edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RESET;
      busy_cnt <= '0;
    end else begin
      case (state)
        ST_RESET, ST_BUSY: begin
          if (busy_done) begin
            state <= ST_RUN;
          end else begin
            state    <= ST_BUSY;
            busy_cnt <= busy_cnt + BW'(1);
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_RESET;
      endcase
    end
  end

  // Storage array: no reset so it maps onto inferred RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // Pointers and read data path.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (wr_acc)    wr_ptr <= wr_ptr + AW'(1);
      if (dout_load) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      valid <= valid_nxt;
    end
  end

  // Count and status flags, all updated together from the next occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_count  <= '0;
      full        <= 1'b1;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      prog_full   <= 1'b0;
      prog_empty  <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      wr_rst_busy <= 1'b1;
      rd_rst_busy <= 1'b1;
    end else begin
      data_count  <= count_nxt;
      full        <= busy_nxt || (count_nxt == CW'(DEPTH));
      empty       <= empty_nxt;
      almost_full <= count_nxt >= CW'(DEPTH - 1);
      prog_full   <= count_nxt >= CW'(PROG_FULL_THRESH);
      prog_empty  <= count_nxt <= CW'(PROG_EMPTY_THRESH);
      overflow    <= wr_en & full;
      underflow   <= rd_en & empty;
      wr_rst_busy <= busy_nxt;
      rd_rst_busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param with default parameters (16x16, thresholds 14/2, busy 4).
// Standard-mode vectors run by default; FWFT sequence runs when FIFO_FWFT_EN is defined.
// Inputs change 1 time unit after the rising edge, outputs are checked at that point.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] dout;
  logic        valid, full, almost_full, prog_full, empty, prog_empty;
  logic        overflow, underflow, wr_rst_busy, rd_rst_busy;
  logic [4:0]  data_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] d;
    logic [28:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  fifo_sync_param dut (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .valid       (valid),
    .full        (full),
    .almost_full (almost_full),
    .prog_full   (prog_full),
    .empty       (empty),
    .prog_empty  (prog_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .data_count  (data_count),
    .wr_rst_busy (wr_rst_busy),
    .rd_rst_busy (rd_rst_busy)
  );

  // Packed view: {dout, valid, full, almost_full, prog_full, empty, prog_empty, overflow, underflow, count}
  function automatic logic [28:0] mk(input logic [15:0] d, input logic v, input logic f,
                                     input logic af, input logic pf, input logic e,
                                     input logic pe, input logic ov, input logic un,
                                     input logic [4:0] c);
    return {d, v, f, af, pf, e, pe, ov, un, c};
  endfunction

  function automatic logic [28:0] act();
    return {dout, valid, full, almost_full, prog_full, empty, prog_empty,
            overflow, underflow, data_count};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [15:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] c;
    // ---- vector table: fill to full, overflow, drain, underflow ----
    for (int i = 0; i < 16; i++) begin
      c = 5'(i + 1);
      tbl.push_back('{1'b1, 1'b0, 16'(i),
        mk(16'h0, 1'b0, c == 5'd16, c >= 5'd15, c >= 5'd14, 1'b0, c <= 5'd2, 1'b0, 1'b0, c)});
    end
    tbl.push_back('{1'b1, 1'b0, 16'hDEAD, mk(16'h0, 0, 1, 1, 1, 0, 0, 1, 0, 5'd16)});
    tbl.push_back('{1'b0, 1'b0, 16'h0,    mk(16'h0, 0, 1, 1, 1, 0, 0, 0, 0, 5'd16)});
    for (int i = 0; i < 16; i++) begin
      c = 5'(15 - i);
      tbl.push_back('{1'b0, 1'b1, 16'h0,
        mk(16'(i), 1'b1, 1'b0, c >= 5'd15, c >= 5'd14, c == 5'd0, c <= 5'd2, 1'b0, 1'b0, c)});
    end
    tbl.push_back('{1'b0, 1'b1, 16'h0, mk(16'h000F, 0, 0, 0, 0, 1, 1, 0, 1, 5'd0)});
    tbl.push_back('{1'b0, 1'b0, 16'h0, mk(16'h000F, 0, 0, 0, 0, 1, 1, 0, 0, 5'd0)});

    // ---- reset and busy sequence ----
    resetn = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    din    = '0;
    #12;
    chk("reset_flags", 32'(act()), 32'(mk(16'h0, 0, 1, 0, 0, 1, 1, 0, 0, 5'd0)));
    chk("reset_busy", {wr_rst_busy, rd_rst_busy}, 2'b11);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    chk("busy_edge1", {wr_rst_busy, rd_rst_busy, full, empty}, 4'b1111);
    step(1'b1, 1'b0, 16'h5555);
    chk("busy_wr_ovf", {wr_rst_busy, overflow, full, data_count}, {3'b111, 5'd0});
    step(1'b0, 1'b0, 16'h0);
    chk("busy_edge3", {wr_rst_busy, rd_rst_busy, overflow, full}, 4'b1101);
    step(1'b0, 1'b0, 16'h0);
    chk("busy_done_busy", {wr_rst_busy, rd_rst_busy}, 2'b00);
    chk("busy_done_flags", 32'(act()), 32'(mk(16'h0, 0, 0, 0, 0, 1, 1, 0, 0, 5'd0)));

`ifndef FIFO_FWFT_EN
    // ---- table-driven fill / drain ----
    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl[%0d]", i), 32'(act()), 32'(tbl[i].exp));
    end

    // ---- simultaneous read/write at empty ----
    step(1'b1, 1'b1, 16'h0042);
    chk("simul_empty", 32'(act()), 32'(mk(16'h000F, 0, 0, 0, 0, 0, 1, 0, 1, 5'd1)));
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i));
    chk("refill_full", 32'(act()), 32'(mk(16'h000F, 0, 1, 1, 1, 0, 0, 0, 0, 5'd16)));

    // ---- simultaneous read/write at full ----
    step(1'b1, 1'b1, 16'hBEEF);
    chk("simul_full", 32'(act()), 32'(mk(16'h0042, 1, 0, 1, 1, 0, 0, 1, 0, 5'd15)));
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 16'h0);
      chk($sformatf("drain_%0d", i), {valid, dout}, {1'b1, 16'h0100 + 16'(i)});
    end
    step(1'b0, 1'b0, 16'h0);
    chk("no_beef", {empty, data_count}, {1'b1, 5'd0});

    // ---- wrap with three words in flight ----
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'h2000 + 16'(k));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 16'h2003 + 16'(i));
      chk($sformatf("wrap_%0d", i), {full, data_count, valid, dout},
          {1'b0, 5'd3, 1'b1, 16'h2000 + 16'(i)});
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 16'h0);
      chk($sformatf("wrap_tail_%0d", k), {data_count, valid, dout},
          {5'(2 - k), 1'b1, 16'h2028 + 16'(k)});
    end

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'h3000 + 16'(i));
    chk("pre_reset_cnt", {data_count, dout}, {5'd9, 16'h202A});
    wr_en = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset", 32'(act()), 32'(mk(16'h0, 0, 1, 0, 0, 1, 1, 0, 0, 5'd0)));
    chk("async_busy", {wr_rst_busy, rd_rst_busy}, 2'b11);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0);
    chk("rerun_state", {wr_rst_busy, full, empty, data_count}, {3'b001, 5'd0});
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 16'h0);
    chk("first_after_reset", {valid, dout, data_count}, {1'b1, 16'h1234, 5'd0});
`else
    // ---- first-word-fall-through ----
    step(1'b1, 1'b0, 16'hA5A5);
    chk("fwft_edge1", {valid, empty, data_count}, {2'b01, 5'd1});
    step(1'b0, 1'b0, 16'h0);
    chk("fwft_edge2", 32'(act()), 32'(mk(16'hA5A5, 1, 0, 0, 0, 0, 1, 0, 0, 5'd1)));
    step(1'b0, 1'b1, 16'h0);
    chk("fwft_pop", 32'(act()), 32'(mk(16'hA5A5, 0, 0, 0, 0, 1, 1, 0, 0, 5'd0)));
    step(1'b0, 1'b1, 16'h0);
    chk("fwft_unf", 32'(act()), 32'(mk(16'hA5A5, 0, 0, 0, 0, 1, 1, 0, 1, 5'd0)));
    step(1'b1, 1'b0, 16'h0001);
    step(1'b1, 1'b0, 16'h0002);
    step(1'b0, 1'b0, 16'h0);
    chk("fwft_two", {valid, dout, data_count}, {1'b1, 16'h0001, 5'd2});
    step(1'b0, 1'b1, 16'h0);
    chk("fwft_next", {valid, dout, data_count}, {1'b1, 16'h0002, 5'd1});
    step(1'b0, 1'b1, 16'h0);
    chk("fwft_drained", {empty, valid, data_count}, {2'b10, 5'd0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
